// File: rtl/phone_pkt_pkg.sv
// Shared definitions for the outgoing packet path: buffer geometry, requester IDs
// and the arbiter state type.
package phone_pkt_pkg;

  localparam int unsigned PKT_WORDS   = 16;
  localparam int unsigned PKT_INDEX_W = 4;
  localparam int unsigned PKT_DATA_W  = 16;

  localparam logic REQ_KEY   = 1'b0;
  localparam logic REQ_VOICE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OWNED,
    ST_START,
    ST_WAIT_RISE,
    ST_WAIT_FALL
  } arb_state_e;

  function automatic logic [1:0] req_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tx_watchdog.sv
// Counts cycles spent waiting on the transmitter; expired_o holds once the
// count reaches TIMEOUT_CYCLES-1 so the counter can never wrap.
module tx_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/outgoing_packet_arbiter.sv
// Arbitrates the outgoing packet buffer between the key-exchange FSM and the
// voice packetizer, then launches and supervises the transmitter.
module outgoing_packet_arbiter
  import phone_pkt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned PRIORITY_KEY   = 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [1:0]             req_i,
  input  logic [1:0]             release_i,
  input  logic [PKT_INDEX_W-1:0] wr_index_0_i,
  input  logic [PKT_INDEX_W-1:0] wr_index_1_i,
  input  logic [PKT_DATA_W-1:0]  wr_data_0_i,
  input  logic [PKT_DATA_W-1:0]  wr_data_1_i,
  input  logic                   wr_en_0_i,
  input  logic                   wr_en_1_i,
  output logic [1:0]             grant_o,
  output logic [PKT_INDEX_W-1:0] outgoing_packet_write_index_o,
  output logic [PKT_DATA_W-1:0]  outgoing_packet_write_data_o,
  output logic                   outgoing_packet_write_enable_o,
  output logic                   tx_start_o,
  input  logic                   tx_busy_i,
  output logic [1:0]             sent_o,
  output logic                   tx_timeout_o
);

  arb_state_e state_q;
  logic       owner_q;
  logic       owner_d;
  logic       rr_q;
  logic [1:0] grant_q;
  logic       tx_start_q;
  logic [1:0] sent_q;
  logic       tx_timeout_q;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;

  // rr_q names the requester that wins a tie in round-robin mode
  always_comb begin
    owner_d = REQ_KEY;
    if (req_i[REQ_VOICE] &&
        (!req_i[REQ_KEY] || (PRIORITY_KEY == 0 && rr_q == REQ_VOICE))) begin
      owner_d = REQ_VOICE;
    end
  end

  assign wd_clear  = (state_q == ST_START) || (state_q == ST_WAIT_RISE && tx_busy_i);
  assign wd_enable = (state_q == ST_WAIT_RISE) || (state_q == ST_WAIT_FALL);

  tx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clock_i),
    .rst_i    (reset_i),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_KEY;
      rr_q         <= REQ_KEY;
      grant_q      <= '0;
      tx_start_q   <= 1'b0;
      sent_q       <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      sent_q     <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            owner_q <= owner_d;
            grant_q <= req_onehot(owner_d);
            state_q <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (release_i[owner_q]) begin
            grant_q    <= '0;
            tx_start_q <= 1'b1;
            state_q    <= ST_START;
          end else if (!req_i[owner_q]) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_START: state_q <= ST_WAIT_RISE;
        ST_WAIT_RISE: begin
          if (tx_busy_i) begin
            state_q <= ST_WAIT_FALL;
          end else if (wd_expired) begin
            tx_timeout_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_WAIT_FALL: begin
          if (!tx_busy_i) begin
            sent_q  <= req_onehot(owner_q);
            rr_q    <= ~owner_q;
            state_q <= ST_IDLE;
          end else if (wd_expired) begin
            tx_timeout_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // grant_q is only non-zero while OWNED, so the buffer is idle during transmission
  always_comb begin
    outgoing_packet_write_index_o  = '0;
    outgoing_packet_write_data_o   = '0;
    outgoing_packet_write_enable_o = 1'b0;
    if (grant_q[REQ_KEY]) begin
      outgoing_packet_write_index_o  = wr_index_0_i;
      outgoing_packet_write_data_o   = wr_data_0_i;
      outgoing_packet_write_enable_o = wr_en_0_i;
    end else if (grant_q[REQ_VOICE]) begin
      outgoing_packet_write_index_o  = wr_index_1_i;
      outgoing_packet_write_data_o   = wr_data_1_i;
      outgoing_packet_write_enable_o = wr_en_1_i;
    end
  end

  assign grant_o      = grant_q;
  assign tx_start_o   = tx_start_q;
  assign sent_o       = sent_q;
  assign tx_timeout_o = tx_timeout_q;

endmodule

// File: tb/tb_outgoing_packet_arbiter.sv
// Bench for outgoing_packet_arbiter: directed vector table, hand-written corner
// sequences and a randomized run checked against a cycle-level reference model.
module tb_outgoing_packet_arbiter;

  localparam int unsigned TO = 8;
  localparam int S_IDLE  = 0;
  localparam int S_OWN   = 1;
  localparam int S_START = 2;
  localparam int S_RISE  = 3;
  localparam int S_FALL  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  req, rel;
  logic [3:0]  idx0, idx1;
  logic [15:0] dat0, dat1;
  logic        en0, en1, busy;

  logic [1:0]  a_grant, b_grant, a_sent, b_sent;
  logic [3:0]  a_widx, b_widx;
  logic [15:0] a_wdat, b_wdat;
  logic        a_wen, b_wen, a_txs, b_txs, a_to, b_to;

  int total = 0;
  int bad   = 0;

  outgoing_packet_arbiter #(.TIMEOUT_CYCLES(TO), .PRIORITY_KEY(1)) dut_a (
    .clock_i(clk), .reset_i(rst), .req_i(req), .release_i(rel),
    .wr_index_0_i(idx0), .wr_index_1_i(idx1), .wr_data_0_i(dat0), .wr_data_1_i(dat1),
    .wr_en_0_i(en0), .wr_en_1_i(en1), .grant_o(a_grant),
    .outgoing_packet_write_index_o(a_widx), .outgoing_packet_write_data_o(a_wdat),
    .outgoing_packet_write_enable_o(a_wen), .tx_start_o(a_txs), .tx_busy_i(busy),
    .sent_o(a_sent), .tx_timeout_o(a_to)
  );

  outgoing_packet_arbiter #(.TIMEOUT_CYCLES(TO), .PRIORITY_KEY(0)) dut_b (
    .clock_i(clk), .reset_i(rst), .req_i(req), .release_i(rel),
    .wr_index_0_i(idx0), .wr_index_1_i(idx1), .wr_data_0_i(dat0), .wr_data_1_i(dat1),
    .wr_en_0_i(en0), .wr_en_1_i(en1), .grant_o(b_grant),
    .outgoing_packet_write_index_o(b_widx), .outgoing_packet_write_data_o(b_wdat),
    .outgoing_packet_write_enable_o(b_wen), .tx_start_o(b_txs), .tx_busy_i(busy),
    .sent_o(b_sent), .tx_timeout_o(b_to)
  );

  typedef struct {
    logic [1:0]  rq, rl;
    logic        e0;
    logic [3:0]  i0;
    logic [15:0] d0;
    logic        e1;
    logic [3:0]  i1;
    logic [15:0] d1;
    logic        bz;
    logic [1:0]  g;
    logic        we;
    logic [3:0]  wi;
    logic [15:0] wd;
    logic        ts;
    logic [1:0]  st;
    logic        to;
  } vec_t;

  vec_t tbl[$];
  logic [1:0] rr_exp [3];

  // reference model state, one slot per DUT (0: key priority, 1: round-robin)
  int         m_stage [2];
  int         m_owner [2];
  int         m_last  [2];
  int         m_wait  [2];
  logic [1:0] e_grant [2];
  logic [1:0] e_sent  [2];
  logic       e_ts    [2];
  logic       e_to    [2];

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] rl,
                              input logic e0, input logic [3:0] i0, input logic [15:0] d0,
                              input logic e1, input logic [3:0] i1, input logic [15:0] d1,
                              input logic bz, input logic [1:0] g, input logic we,
                              input logic [3:0] wi, input logic [15:0] wd, input logic ts,
                              input logic [1:0] st, input logic to);
    vec_t v;
    v.rq = rq; v.rl = rl; v.e0 = e0; v.i0 = i0; v.d0 = d0; v.e1 = e1; v.i1 = i1; v.d1 = d1;
    v.bz = bz; v.g = g; v.we = we; v.wi = wi; v.wd = wd; v.ts = ts; v.st = st; v.to = to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = 2'b00; rel = 2'b00; busy = 1'b0;
    idx0 = 4'h0; idx1 = 4'h0; dat0 = 16'h0; dat1 = 16'h0; en0 = 1'b0; en1 = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    #7;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_stage[k] = S_IDLE; m_owner[k] = 0; m_last[k] = 1; m_wait[k] = 0;
      e_grant[k] = 2'b00; e_sent[k] = 2'b00; e_ts[k] = 1'b0; e_to[k] = 1'b0;
    end
  endtask

  // advances model k by one clock edge using the inputs present at that edge
  task automatic model_step(input int k);
    int o;
    e_ts[k]   = 1'b0;
    e_sent[k] = 2'b00;
    o = m_owner[k];
    case (m_stage[k])
      S_IDLE: if (req != 2'b00) begin
        if (req == 2'b11) o = (k == 0) ? 0 : 1 - m_last[k];
        else              o = req[0] ? 0 : 1;
        m_owner[k] = o;
        e_grant[k] = (o == 0) ? 2'b01 : 2'b10;
        m_stage[k] = S_OWN;
      end
      S_OWN: begin
        if (rel[o]) begin
          e_grant[k] = 2'b00; e_ts[k] = 1'b1; m_stage[k] = S_START;
        end else if (!req[o]) begin
          e_grant[k] = 2'b00; m_stage[k] = S_IDLE;
        end
      end
      S_START: begin
        m_stage[k] = S_RISE; m_wait[k] = 0;
      end
      S_RISE: begin
        if (busy) begin
          m_stage[k] = S_FALL; m_wait[k] = 0;
        end else begin
          m_wait[k]++;
          if (m_wait[k] == TO) begin e_to[k] = 1'b1; m_stage[k] = S_IDLE; end
        end
      end
      S_FALL: begin
        if (!busy) begin
          e_sent[k] = (o == 0) ? 2'b01 : 2'b10; m_last[k] = o; m_stage[k] = S_IDLE;
        end else begin
          m_wait[k]++;
          if (m_wait[k] == TO) begin e_to[k] = 1'b1; m_stage[k] = S_IDLE; end
        end
      end
      default: m_stage[k] = S_IDLE;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [20:0] wexp, wact;
    int c;
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;

    // single transmission by requester 0
    tbl.push_back(mk(2'b01,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b01,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    tbl.push_back(mk(2'b01,2'b00,1'b1,4'h3,16'h5555,1'b0,4'h0,16'h0000,1'b0, 2'b01,1'b1,4'h3,16'h5555,1'b0,2'b00,1'b0));
    tbl.push_back(mk(2'b01,2'b01,1'b1,4'h3,16'h5555,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b1,2'b00,1'b0));
    tbl.push_back(mk(2'b00,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(2'b00,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b1, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    tbl.push_back(mk(2'b00,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b01,1'b0));
    tbl.push_back(mk(2'b00,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    // simultaneous requests with key priority; voice writes are blocked
    tbl.push_back(mk(2'b11,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b01,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    tbl.push_back(mk(2'b11,2'b00,1'b0,4'h0,16'h0000,1'b1,4'h5,16'hAAAA,1'b0, 2'b01,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    tbl.push_back(mk(2'b11,2'b01,1'b0,4'h0,16'h0000,1'b1,4'h5,16'hAAAA,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b1,2'b00,1'b0));
    tbl.push_back(mk(2'b11,2'b00,1'b0,4'h0,16'h0000,1'b1,4'h5,16'hAAAA,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    tbl.push_back(mk(2'b11,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b1, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    tbl.push_back(mk(2'b10,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b01,1'b0));
    tbl.push_back(mk(2'b10,2'b00,1'b0,4'h0,16'h0000,1'b1,4'h5,16'hAAAA,1'b0, 2'b10,1'b1,4'h5,16'hAAAA,1'b0,2'b00,1'b0));
    // voice sends, transmitter never responds: timeout 8 cycles after WAIT_RISE entry
    tbl.push_back(mk(2'b10,2'b10,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b1,2'b00,1'b0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(2'b00,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b0));
    tbl.push_back(mk(2'b00,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b1));
    // normal grant after timeout, then abandon without release
    tbl.push_back(mk(2'b01,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b01,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b1));
    tbl.push_back(mk(2'b00,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b1));
    tbl.push_back(mk(2'b00,2'b00,1'b0,4'h0,16'h0000,1'b0,4'h0,16'h0000,1'b0, 2'b00,1'b0,4'h0,16'h0000,1'b0,2'b00,1'b1));

    do_reset();
    chk("reset grant", 32'(a_grant), 32'(2'b00));
    chk("reset tx_start", 32'(a_txs), 32'(1'b0));
    chk("reset sent", 32'(a_sent), 32'(2'b00));
    chk("reset tx_timeout", 32'(a_to), 32'(1'b0));
    chk("reset wr_en", 32'(a_wen), 32'(1'b0));

    foreach (tbl[i]) begin
      req = tbl[i].rq; rel = tbl[i].rl; busy = tbl[i].bz;
      en0 = tbl[i].e0; idx0 = tbl[i].i0; dat0 = tbl[i].d0;
      en1 = tbl[i].e1; idx1 = tbl[i].i1; dat1 = tbl[i].d1;
      tick();
      chk($sformatf("row%0d grant", i),   32'(a_grant), 32'(tbl[i].g));
      chk($sformatf("row%0d wr_en", i),   32'(a_wen),   32'(tbl[i].we));
      chk($sformatf("row%0d wr_idx", i),  32'(a_widx),  32'(tbl[i].wi));
      chk($sformatf("row%0d wr_data", i), 32'(a_wdat),  32'(tbl[i].wd));
      chk($sformatf("row%0d tx_start", i),32'(a_txs),   32'(tbl[i].ts));
      chk($sformatf("row%0d sent", i),    32'(a_sent),  32'(tbl[i].st));
      chk($sformatf("row%0d timeout", i), 32'(a_to),    32'(tbl[i].to));
    end
    clear_inputs();

    // async reset while in WAIT_FALL with the sticky timeout still set
    req = 2'b10;
    tick();
    chk("ar grant", 32'(a_grant), 32'(2'b10));
    rel = 2'b10;
    tick();
    rel = 2'b00; req = 2'b00;
    chk("ar tx_start", 32'(a_txs), 32'(1'b1));
    tick();
    busy = 1'b1;
    tick();
    chk("ar timeout before reset", 32'(a_to), 32'(1'b1));
    #3;
    rst = 1'b1;
    #1;
    chk("ar grant in reset", 32'(a_grant), 32'(2'b00));
    chk("ar tx_start in reset", 32'(a_txs), 32'(1'b0));
    chk("ar sent in reset", 32'(a_sent), 32'(2'b00));
    chk("ar timeout in reset", 32'(a_to), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0; busy = 1'b0; req = 2'b10;
    tick();
    chk("ar grant after reset", 32'(a_grant), 32'(2'b10));

    // round-robin: both held requesting through three transmissions
    do_reset();
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      c = 0;
      while (b_grant == 2'b00 && c < 20) begin tick(); c++; end
      chk($sformatf("rr%0d grant", t), 32'(b_grant), 32'(rr_exp[t]));
      rel = b_grant;
      tick();
      rel = 2'b00;
      tick();
      busy = 1'b1;
      tick(); tick(); tick();
      busy = 1'b0;
      c = 0;
      while (b_sent == 2'b00 && c < 20) begin tick(); c++; end
      chk($sformatf("rr%0d sent", t), 32'(b_sent), 32'(rr_exp[t]));
    end

    // randomized run against the reference model, with periodic resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 1000 == 0) begin
        do_reset();
        model_reset();
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        model_step(k);
        wexp = e_grant[k][0] ? {en0, idx0, dat0} : (e_grant[k][1] ? {en1, idx1, dat1} : 21'd0);
        wact = (k == 0) ? {a_wen, a_widx, a_wdat} : {b_wen, b_widx, b_wdat};
        chk($sformatf("rand c%0d d%0d grant", cyc, k), 32'((k == 0) ? a_grant : b_grant), 32'(e_grant[k]));
        chk($sformatf("rand c%0d d%0d tx_start", cyc, k), 32'((k == 0) ? a_txs : b_txs), 32'(e_ts[k]));
        chk($sformatf("rand c%0d d%0d sent", cyc, k), 32'((k == 0) ? a_sent : b_sent), 32'(e_sent[k]));
        chk($sformatf("rand c%0d d%0d timeout", cyc, k), 32'((k == 0) ? a_to : b_to), 32'(e_to[k]));
        chk($sformatf("rand c%0d d%0d write", cyc, k), 32'(wact), 32'(wexp));
      end
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
        rel[b] = ($urandom_range(3) == 0);
      end
      en0 = 1'($urandom_range(1)); idx0 = 4'($urandom); dat0 = 16'($urandom);
      en1 = 1'($urandom_range(1)); idx1 = 4'($urandom); dat1 = 16'($urandom);
      if ($urandom_range(3) == 0) busy = ~busy;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/outgoing_packet_arbiter.md
Name: outgoing_packet_arbiter

Overview:
- Shares the single outgoing packet buffer (16 words x 16 bits, 4-bit index) and the packet transmitter between two requesters.
  - Requester 0 is the key-exchange sending FSM.
  - Requester 1 is the voice packetizer.
- Grants buffer write access to one requester at a time and muxes its write port onto the buffer.
- When the owner releases, pulses the transmitter start and holds off new grants until transmission completes or times out.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles to wait for tx_busy to rise, then fall, before aborting.
- PRIORITY_KEY, 1: 1 = requester 0 always wins simultaneous requests; 0 = round-robin.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  2  per-requester request level; bit0 key FSM, bit1 voice
- release  in  2  per-requester one-cycle pulse: buffer filled, send it
- wr_index_0 / wr_index_1  in  4  requester write index
- wr_data_0 / wr_data_1  in  16  requester write data
- wr_en_0 / wr_en_1  in  1  requester write enable
- grant  out  2  one-hot grant (or 0)
- outgoing_packet_write_index  out  4  muxed buffer index
- outgoing_packet_write_data  out  16  muxed buffer data
- outgoing_packet_write_enable  out  1  muxed buffer enable
- tx_start  out  1  one-cycle transmitter start pulse
- tx_busy  in  1  transmitter busy level
- sent  out  2  one-cycle pulse to owner: packet transmitted
- tx_timeout  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (async, immediate):
  - All outputs 0 (grant, write port, tx_start, sent, tx_timeout).
  - State IDLE; round-robin pointer = requester 0.
- States: IDLE, OWNED, START, WAIT_RISE, WAIT_FALL.
- IDLE:
  - If any req bit is set, register grant next cycle.
  - Simultaneous req: PRIORITY_KEY=1 picks bit0. PRIORITY_KEY=0 picks the requester not served last, then flips the pointer after each completed transmission.
  - Grant latency is 1 cycle from req seen high.
  - Go to OWNED.
- OWNED:
  - Write port is combinationally muxed from the owner's inputs; zero added latency.
  - Non-owner wr_en is ignored and never reaches the buffer.
  - Owner release pulse: drop grant next cycle and go to START.
  - Owner drops req without release: drop grant and return to IDLE with no transmission; abandoned packet.
  - release from the non-owner is ignored.
- START:
  - tx_start=1 for exactly one cycle.
  - Timeout counter cleared.
  - Go to WAIT_RISE.
- WAIT_RISE:
  - Wait for tx_busy=1, then go to WAIT_FALL.
  - Counter reaching TIMEOUT_CYCLES-1: set tx_timeout, return to IDLE, no sent pulse.
- WAIT_FALL:
  - tx_busy=0 pulses sent[owner] one cycle, updates the RR pointer, and returns to IDLE.
  - Same timeout rule as WAIT_RISE; the counter restarts on entry.
- Write port is driven to 0 whenever grant=0. The buffer is never written while a packet is in flight.
- Requests arriving in START/WAIT_* are held pending. They are served on return to IDLE, with the next grant at IDLE+1.
- Same requester re-requesting back-to-back is legal. In round-robin mode the other requester wins if both are pending.
- Counter width is clog2(TIMEOUT_CYCLES); no wrap is reachable.

Decomposition:
- Shared package, phone_pkt_pkg:
  - PKT_WORDS=16, PKT_INDEX_W=4, PKT_DATA_W=16
  - requester ID constants REQ_KEY=0, REQ_VOICE=1
  - arbiter state encoding
- One natural sub-module: tx_watchdog (clear, enable, expired) holding the timeout counter.

Test Plan:
- Grant and transmit:
  - Stimulus: req=01 alone; requester 0 writes index 3 data 16'h5555; release; tx_busy high 5 cycles.
  - Required: grant=01 one cycle after req; buffer sees write idx 3 / 16'h5555; tx_start one pulse; sent=01 one cycle after tx_busy falls.
- Simultaneous requests, PRIORITY_KEY=1:
  - Stimulus: req=11 in IDLE.
  - Required: grant=01. Requester 1 writing 16'hAAAA with wr_en_1=1 produces no buffer write. grant=10 only after requester 0's sent pulse.
- Round-robin, PRIORITY_KEY=0:
  - Stimulus: req=11 held through three complete transmissions.
  - Required: grant order 01, 10, 01.
- Abandon:
  - Stimulus: owner drops req in OWNED with no release.
  - Required: grant=00 next cycle; no tx_start; state IDLE.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; tx_busy stuck 0 after tx_start.
  - Required: tx_timeout=1 exactly 8 cycles after WAIT_RISE entry; no sent; next req is granted normally.
- Async reset mid-transmission:
  - Stimulus: assert reset during WAIT_FALL, between clock edges.
  - Required: grant, tx_start, sent and tx_timeout go to 0 immediately; after release, req=10 gets grant=10.
